// File: rtl/int_sequencer_pkg.sv
// Shared state encoding, default geometry and constants for the INT/RTI sequencer.
package int_sequencer_pkg;

   localparam int          PC_W_DEF     = 32;
   localparam int          WORD_W_DEF   = 16;
   localparam int          FLAG_W_DEF   = 3;
   localparam logic [31:0] VEC_ADDR_DEF = 32'h0000_0000;
   localparam logic [1:0]  FLUSH_CNT    = 2'd2;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_DRAIN    = 4'd1,
      S_PUSH_LO  = 4'd2,
      S_PUSH_HI  = 4'd3,
      S_PUSH_FLG = 4'd4,
      S_VEC_LO   = 4'd5,
      S_VEC_HI   = 4'd6,
      S_LOAD     = 4'd7,
      S_R_DRAIN  = 4'd8,
      S_POP_FLG  = 4'd9,
      S_POP_HI   = 4'd10,
      S_POP_LO   = 4'd11,
      S_R_LOAD   = 4'd12
   } seq_state_t;

   // True in the two states that wait for the memory port to go quiet.
   function automatic logic is_drain(input seq_state_t s);
      return (s == S_DRAIN) || (s == S_R_DRAIN);
   endfunction

endpackage

// File: rtl/int_sequencer_if.sv
// Stack / data-memory port borrowed by the sequencer while a sequence runs.
interface int_sequencer_if
   import int_sequencer_pkg::*;
#(
   parameter int PC_W   = PC_W_DEF,
   parameter int WORD_W = WORD_W_DEF
) ();

   logic              push_en;
   logic              pop_en;
   logic [WORD_W-1:0] push_data;
   logic              mem_rd;
   logic [PC_W-1:0]   mem_addr;
   logic [WORD_W-1:0] rd_data;
   logic              mem_busy;

   modport master (
      output push_en, pop_en, push_data, mem_rd, mem_addr,
      input  rd_data, mem_busy
   );

   modport slave (
      input  push_en, pop_en, push_data, mem_rd, mem_addr,
      output rd_data, mem_busy
   );

endinterface

// File: rtl/int_sequencer_edge.sv
// Rising-edge detector on the interrupt line with a pending latch that holds
// the request until the sequencer accepts it.
module int_edge_latch (
   input  logic clk,
   input  logic rst,
   input  logic int_req,
   input  logic pend_clr,
   output logic int_pend
);

   logic int_req_q_r;
   logic int_pend_r;
   logic rise_s;

   assign rise_s   = int_req & ~int_req_q_r;
   assign int_pend = int_pend_r;

   // A new edge wins over a same-cycle clear so no request is lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         int_req_q_r <= 1'b0;
         int_pend_r  <= 1'b0;
      end else begin
         int_req_q_r <= int_req;
         if (rise_s) begin
            int_pend_r <= 1'b1;
         end else if (pend_clr) begin
            int_pend_r <= 1'b0;
         end else begin
            int_pend_r <= int_pend_r;
         end
      end
   end

endmodule

// File: rtl/int_sequencer.sv
// Multi-cycle interrupt entry / RTI return sequencer: saves PC and flags on the
// stack, fetches the vector, and restores state on return.
module int_sequencer
   import int_sequencer_pkg::*;
#(
   parameter int              PC_W     = PC_W_DEF,
   parameter int              WORD_W   = WORD_W_DEF,
   parameter int              FLAG_W   = FLAG_W_DEF,
   parameter logic [PC_W-1:0] VEC_ADDR = PC_W'(VEC_ADDR_DEF)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                int_req,
   input  logic                rti_dec,
   input  logic [PC_W-1:0]     pc_resume,
   input  logic [FLAG_W-1:0]   flags_in,
   int_sequencer_if.master     mem,
   output logic                busy,
   output logic                stall_fetch,
   output logic [1:0]          flush_num,
   output logic                pc_load,
   output logic [PC_W-1:0]     pc_load_val,
   output logic                flags_load,
   output logic [FLAG_W-1:0]   flags_out,
   output logic                in_isr
);

   seq_state_t        state_r;
   seq_state_t        next_s;
   logic              first_r;
   logic              int_pend_s;
   logic              pend_clr_s;
   logic              start_s;
   logic [PC_W-1:0]   pc_r;
   logic [FLAG_W-1:0] flg_r;
   logic [FLAG_W-1:0] rflg_r;
   logic [WORD_W-1:0] lo_r;
   logic [WORD_W-1:0] hi_r;
   logic              in_isr_r;

   int_edge_latch u_edge (
      .clk      (clk),
      .rst      (rst),
      .int_req  (int_req),
      .pend_clr (pend_clr_s),
      .int_pend (int_pend_s)
   );

   assign start_s = (state_r == S_IDLE) && (next_s != S_IDLE);
   assign in_isr  = in_isr_r;

   // State register; first_r marks the opening cycle of a drain state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IDLE;
         first_r <= 1'b0;
      end else begin
         state_r <= next_s;
         first_r <= start_s;
      end
   end

   // Return address / flag capture on entry and stack/vector word captures.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_r     <= {PC_W{1'b0}};
         flg_r    <= {FLAG_W{1'b0}};
         rflg_r   <= {FLAG_W{1'b0}};
         lo_r     <= {WORD_W{1'b0}};
         hi_r     <= {WORD_W{1'b0}};
         in_isr_r <= 1'b0;
      end else begin
         if (start_s) begin
            pc_r <= pc_resume;
            if (next_s == S_DRAIN) begin
               flg_r <= flags_in;
            end
         end
         case (state_r)
            S_VEC_HI: lo_r     <= mem.rd_data;
            S_POP_HI: rflg_r   <= mem.rd_data[FLAG_W-1:0];
            S_POP_LO: hi_r     <= mem.rd_data;
            S_LOAD:   in_isr_r <= 1'b1;
            S_R_LOAD: in_isr_r <= 1'b0;
            default:  in_isr_r <= in_isr_r;
         endcase
      end
   end

   // Next-state selection and per-state output decode.
   always_comb begin
      next_s        = state_r;
      pend_clr_s    = 1'b0;
      busy          = (state_r != S_IDLE);
      stall_fetch   = (state_r != S_IDLE);
      flush_num     = 2'd0;
      mem.push_en   = 1'b0;
      mem.pop_en    = 1'b0;
      mem.push_data = {WORD_W{1'b0}};
      mem.mem_rd    = 1'b0;
      mem.mem_addr  = {PC_W{1'b0}};
      pc_load       = 1'b0;
      pc_load_val   = {PC_W{1'b0}};
      flags_load    = 1'b0;
      flags_out     = {FLAG_W{1'b0}};

      if (is_drain(state_r) && first_r) begin
         flush_num = FLUSH_CNT;
      end else begin
         flush_num = 2'd0;
      end

      case (state_r)
         S_IDLE: begin
            // RTI has priority; a simultaneous INT edge stays pending.
            if (rti_dec) begin
               next_s = S_R_DRAIN;
            end else if (int_pend_s && !in_isr_r) begin
               next_s     = S_DRAIN;
               pend_clr_s = 1'b1;
            end else begin
               next_s = S_IDLE;
            end
         end
         S_DRAIN: begin
            if (mem.mem_busy) begin
               next_s = S_DRAIN;
            end else begin
               next_s = S_PUSH_LO;
            end
         end
         S_PUSH_LO: begin
            mem.push_en   = 1'b1;
            mem.push_data = pc_r[WORD_W-1:0];
            next_s        = S_PUSH_HI;
         end
         S_PUSH_HI: begin
            mem.push_en   = 1'b1;
            mem.push_data = pc_r[PC_W-1:WORD_W];
            next_s        = S_PUSH_FLG;
         end
         S_PUSH_FLG: begin
            mem.push_en   = 1'b1;
            mem.push_data = {{(WORD_W-FLAG_W){1'b0}}, flg_r};
            next_s        = S_VEC_LO;
         end
         S_VEC_LO: begin
            mem.mem_rd   = 1'b1;
            mem.mem_addr = VEC_ADDR;
            next_s       = S_VEC_HI;
         end
         S_VEC_HI: begin
            mem.mem_rd   = 1'b1;
            mem.mem_addr = VEC_ADDR + PC_W'(1);
            next_s       = S_LOAD;
         end
         S_LOAD: begin
            pc_load     = 1'b1;
            pc_load_val = {mem.rd_data, lo_r};
            next_s      = S_IDLE;
         end
         S_R_DRAIN: begin
            if (mem.mem_busy) begin
               next_s = S_R_DRAIN;
            end else begin
               next_s = S_POP_FLG;
            end
         end
         S_POP_FLG: begin
            mem.pop_en = 1'b1;
            next_s     = S_POP_HI;
         end
         S_POP_HI: begin
            mem.pop_en = 1'b1;
            next_s     = S_POP_LO;
         end
         S_POP_LO: begin
            mem.pop_en = 1'b1;
            next_s     = S_R_LOAD;
         end
         S_R_LOAD: begin
            pc_load     = 1'b1;
            pc_load_val = {hi_r, mem.rd_data};
            flags_load  = 1'b1;
            flags_out   = rflg_r;
            next_s      = S_IDLE;
         end
         default: begin
            next_s = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_int_sequencer.sv
// Scoreboard bench for int_sequencer: the driver predicts every port event of a
// sequence from the interrupt/return rules, a negedge monitor pops and compares.
module tb_int_sequencer;

   localparam int EV_FLUSH = 0;
   localparam int EV_PUSH  = 1;
   localparam int EV_POP   = 2;
   localparam int EV_RD    = 3;
   localparam int EV_LOAD  = 4;

   typedef struct {
      int          kind;
      int          cyc;
      logic [31:0] data;
      logic [2:0]  fl;
      logic        fload;
   } ev_t;

   typedef struct {
      logic [31:0] pc;
      logic [2:0]  fl;
   } frame_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        int_req = 1'b0;
   logic        rti_dec = 1'b0;
   logic [31:0] pc_resume = 32'h0;
   logic [2:0]  flags_in = 3'h0;
   logic        busy, stall_fetch, pc_load, flags_load, in_isr;
   logic [1:0]  flush_num;
   logic [31:0] pc_load_val;
   logic [2:0]  flags_out;

   ev_t         expq[$];
   frame_t      frames[$];
   logic [15:0] env_stk[$];
   logic [15:0] vec_mem [0:1];
   logic [15:0] next_rd = 16'h0;
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   bit          isr_m = 1'b0;

   int_sequencer_if #(.PC_W(32), .WORD_W(16)) mem_if ();

   int_sequencer #(.PC_W(32), .WORD_W(16), .FLAG_W(3), .VEC_ADDR(32'h0)) dut (
      .clk         (clk),
      .rst         (rst),
      .int_req     (int_req),
      .rti_dec     (rti_dec),
      .pc_resume   (pc_resume),
      .flags_in    (flags_in),
      .mem         (mem_if),
      .busy        (busy),
      .stall_fetch (stall_fetch),
      .flush_num   (flush_num),
      .pc_load     (pc_load),
      .pc_load_val (pc_load_val),
      .flags_load  (flags_load),
      .flags_out   (flags_out),
      .in_isr      (in_isr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void add_ev(input int k, input int c, input logic [31:0] d,
                                  input logic [2:0] f, input logic fl);
      ev_t e;
      e.kind = k; e.cyc = c; e.data = d; e.fl = f; e.fload = fl;
      expq.push_back(e);
   endfunction

   // Stack and vector memory environment; read data appears the cycle after the request.
   always @(negedge clk) begin
      if (mem_if.push_en) env_stk.push_back(mem_if.push_data);
      if (mem_if.pop_en) begin
         if (env_stk.size() > 0) next_rd = env_stk.pop_back();
         else next_rd = 16'hdead;
      end
      if (mem_if.mem_rd) next_rd = vec_mem[mem_if.mem_addr[0]];
   end
   always @(posedge clk) mem_if.rd_data <= next_rd;

   // Monitor: every visible event must match the head of the expectation queue.
   always @(negedge clk) begin : mon
      int          n;
      int          k;
      logic [31:0] d;
      ev_t         e;
      n = int'(flush_num != 2'd0) + int'(mem_if.push_en) + int'(mem_if.pop_en)
        + int'(mem_if.mem_rd) + int'(pc_load);
      k = EV_LOAD;
      d = pc_load_val;
      if (flags_load && !pc_load) chk("flags_load_alone", 64'(flags_load), 64'(0));
      if (n > 1) begin
         chk("event_overlap", 64'(n), 64'(1));
      end else if (n == 1) begin
         if (flush_num != 2'd0) begin k = EV_FLUSH; d = {30'h0, flush_num}; end
         else if (mem_if.push_en) begin k = EV_PUSH; d = {16'h0, mem_if.push_data}; end
         else if (mem_if.pop_en) begin k = EV_POP; d = 32'h0; end
         else if (mem_if.mem_rd) begin k = EV_RD; d = mem_if.mem_addr; end
         if (expq.size() == 0) begin
            chk("unexpected_event", 64'(k), 64'(-1));
         end else begin
            e = expq.pop_front();
            chk("ev_kind", 64'(k), 64'(e.kind));
            chk("ev_cycle", 64'(cyc), 64'(e.cyc));
            chk("ev_stall", 64'({busy, stall_fetch}), 64'(2'b11));
            if (k == e.kind && k != EV_POP) chk("ev_data", 64'(d), 64'(e.data));
            if (k == EV_LOAD && e.kind == EV_LOAD) begin
               chk("flags_load", 64'(flags_load), 64'(e.fload));
               if (e.fload) chk("flags_out", 64'(flags_out), 64'(e.fl));
            end
         end
      end
   end

   task automatic expect_int(input int base, input int b, input logic [31:0] pc, input logic [2:0] f);
      frame_t fr;
      add_ev(EV_FLUSH, base + 2, 32'd2, 3'd0, 1'b0);
      add_ev(EV_PUSH, base + 3 + b, {16'h0, pc[15:0]}, 3'd0, 1'b0);
      add_ev(EV_PUSH, base + 4 + b, {16'h0, pc[31:16]}, 3'd0, 1'b0);
      add_ev(EV_PUSH, base + 5 + b, {29'h0, f}, 3'd0, 1'b0);
      add_ev(EV_RD, base + 6 + b, 32'h0, 3'd0, 1'b0);
      add_ev(EV_RD, base + 7 + b, 32'h1, 3'd0, 1'b0);
      add_ev(EV_LOAD, base + 8 + b, {vec_mem[1], vec_mem[0]}, 3'd0, 1'b0);
      fr.pc = pc; fr.fl = f;
      frames.push_back(fr);
      isr_m = 1'b1;
   endtask

   task automatic expect_rti(input int base, input int b);
      frame_t fr;
      if (frames.size() == 0) begin
         fr.pc = $urandom;
         fr.fl = 3'($urandom_range(0, 7));
         env_stk.push_back(fr.pc[15:0]);
         env_stk.push_back(fr.pc[31:16]);
         env_stk.push_back({13'h0, fr.fl});
      end else begin
         fr = frames.pop_back();
      end
      add_ev(EV_FLUSH, base + 1, 32'd2, 3'd0, 1'b0);
      add_ev(EV_POP, base + 2 + b, 32'h0, 3'd0, 1'b0);
      add_ev(EV_POP, base + 3 + b, 32'h0, 3'd0, 1'b0);
      add_ev(EV_POP, base + 4 + b, 32'h0, 3'd0, 1'b0);
      add_ev(EV_LOAD, base + 5 + b, fr.pc, fr.fl, 1'b1);
      isr_m = 1'b0;
   endtask

   task automatic wait_done();
      int guard = 0;
      while (expq.size() != 0 && guard < 200) begin
         @(posedge clk);
         guard++;
      end
      chk("seq_timeout", 64'(expq.size()), 64'(0));
      expq.delete();
      @(posedge clk); #1;
      chk("idle_busy", 64'(busy), 64'(0));
      chk("in_isr", 64'(in_isr), 64'(isr_m));
   endtask

   task automatic issue_int(input logic [31:0] pc, input logic [2:0] f, input int b,
                            input bit hold, input bit junk_rti);
      int base;
      @(posedge clk); #1;
      pc_resume = pc; flags_in = f; int_req = 1'b1;
      mem_if.mem_busy = (b > 0);
      base = cyc;
      expect_int(base, b, pc, f);
      for (int k = 1; k <= b + 3; k++) begin
         @(posedge clk); #1;
         if (!hold) int_req = 1'b0;
         mem_if.mem_busy = (b > 0) && (k <= b + 1);
         rti_dec = junk_rti && (k == 3);
      end
      rti_dec = 1'b0;
      wait_done();
   endtask

   task automatic do_int(input int b, input bit hold, input bit junk_rti);
      vec_mem[0] = 16'($urandom);
      vec_mem[1] = 16'($urandom);
      issue_int($urandom, 3'($urandom_range(0, 7)), b, hold, junk_rti);
   endtask

   task automatic issue_rti(input int b);
      int base;
      @(posedge clk); #1;
      rti_dec = 1'b1;
      mem_if.mem_busy = (b > 0);
      base = cyc;
      expect_rti(base, b);
      for (int k = 1; k <= b + 1; k++) begin
         @(posedge clk); #1;
         rti_dec = 1'b0;
         mem_if.mem_busy = (b > 0) && (k <= b);
      end
      wait_done();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ctl"}, 64'({busy, stall_fetch, flush_num, pc_load, flags_load, in_isr}), 64'(0));
      chk({tag, "_mem"}, 64'({mem_if.push_en, mem_if.pop_en, mem_if.mem_rd,
                              mem_if.push_data, mem_if.mem_addr}), 64'(0));
      chk({tag, "_val"}, 64'({pc_load_val, flags_out}), 64'(0));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          base;
      logic [31:0] pc;
      logic [2:0]  f;
      mem_if.mem_busy = 1'b0;
      vec_mem[0] = 16'h0; vec_mem[1] = 16'h0;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      rst = 1'b0;

      // Reference INT then RTI back to the interrupted code.
      vec_mem[0] = 16'h0100; vec_mem[1] = 16'h0000;
      issue_int(32'h0001_0020, 3'b101, 0, 1'b0, 1'b0);
      issue_rti(0);

      // Drain held by mem_busy; RTI pulse mid-sequence must be ignored.
      do_int(3, 1'b0, 1'b1);
      issue_rti(2);

      // RTI and INT edge together: RTI first, INT right after.
      pc = $urandom; f = 3'($urandom_range(0, 7));
      vec_mem[0] = 16'($urandom); vec_mem[1] = 16'($urandom);
      @(posedge clk); #1;
      pc_resume = pc; flags_in = f; rti_dec = 1'b1; int_req = 1'b1;
      base = cyc;
      expect_rti(base, 0);
      expect_int(base + 5, 0, pc, f);
      @(posedge clk); #1;
      rti_dec = 1'b0; int_req = 1'b0;
      wait_done();

      // Second INT edge inside the ISR waits for RTI, then is serviced.
      @(posedge clk); #1;
      int_req = 1'b1;
      @(posedge clk); #1;
      int_req = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("isr_no_nest", 64'(busy), 64'(0));
      pc = $urandom; f = 3'($urandom_range(0, 7));
      vec_mem[0] = 16'($urandom); vec_mem[1] = 16'($urandom);
      @(posedge clk); #1;
      pc_resume = pc; flags_in = f; rti_dec = 1'b1;
      base = cyc;
      expect_rti(base, 0);
      expect_int(base + 5, 0, pc, f);
      @(posedge clk); #1;
      rti_dec = 1'b0;
      wait_done();
      issue_rti(0);

      // int_req held high produces one interrupt only.
      do_int(0, 1'b1, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      chk("held_req_once", 64'(busy), 64'(0));
      int_req = 1'b0;
      issue_rti(1);

      // Reset during PUSH_HI with a second edge pending.
      vec_mem[0] = 16'($urandom); vec_mem[1] = 16'($urandom);
      pc = $urandom;
      @(posedge clk); #1;
      pc_resume = pc; flags_in = 3'b011; int_req = 1'b1;
      base = cyc;
      add_ev(EV_FLUSH, base + 2, 32'd2, 3'd0, 1'b0);
      add_ev(EV_PUSH, base + 3, {16'h0, pc[15:0]}, 3'd0, 1'b0);
      add_ev(EV_PUSH, base + 4, {16'h0, pc[31:16]}, 3'd0, 1'b0);
      @(posedge clk); #1; int_req = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1; int_req = 1'b1;
      @(posedge clk); #1; int_req = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      check_zero("midrst");
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("midrst_no_pend", 64'(busy), 64'(0));
      chk("midrst_queue", 64'(expq.size()), 64'(0));
      expq.delete();
      env_stk.delete();

      // Randomized mix of interrupts and returns.
      for (int i = 0; i < 16; i++) begin
         if (isr_m) issue_rti($urandom_range(0, 3));
         else if ($urandom_range(0, 2) == 0) issue_rti($urandom_range(0, 3));
         else do_int($urandom_range(0, 3), 1'b0, 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
